// File: rtl/seven_seg_decoder_if.sv
// Digit-side signal bundle for one seven-segment digit: the code and display
// controls driven in, and the registered segment lines and invalid flag back out.
interface seven_seg_decoder_if;
    logic [3:0] bcd;
    logic       blank;
    logic       lamp_test;
    logic [6:0] segments;
    logic       invalid;

    modport master (
        output bcd, blank, lamp_test,
        input  segments, invalid
    );

    modport slave (
        input  bcd, blank, lamp_test,
        output segments, invalid
    );
endinterface

// File: rtl/seven_seg_decoder.sv
// Registered BCD-to-seven-segment decoder for one active-low common-anode digit.
// Build option: define SEVEN_SEG_HEX_EN to show hex letters A-F for codes 10-15.
module seven_seg_decoder (
    input logic                clk,
    input logic                rst,
    seven_seg_decoder_if.slave bus
);

    logic [6:0] glyph;
    logic [6:0] seg_next;
    logic       invalid_next;

    // Active-low patterns: bit0=a .. bit6=g, 0 lights the segment.
    always_comb begin
        glyph = '1;
        unique case (bus.bcd)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
`ifdef SEVEN_SEG_HEX_EN
            4'd10:   glyph = 7'h08;
            4'd11:   glyph = 7'h03;
            4'd12:   glyph = 7'h46;
            4'd13:   glyph = 7'h21;
            4'd14:   glyph = 7'h06;
            4'd15:   glyph = 7'h0E;
`else
            default: glyph = '1;
`endif
        endcase
    end

    // invalid depends only on the code, never on blank/lamp_test or the build.
    always_comb begin
        seg_next     = glyph;
        invalid_next = (bus.bcd >= 4'd10);
        if (bus.lamp_test) begin
            seg_next = '0;
        end else if (bus.blank) begin
            seg_next = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.segments <= '1;
            bus.invalid  <= 1'b0;
        end else begin
            bus.segments <= seg_next;
            bus.invalid  <= invalid_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Scoreboard bench for seven_seg_decoder: directed plan sequences then random
// stimulus, checked against a segment-letter reference model.
module tb_seven_seg_decoder;

    typedef struct {
        logic [6:0] seg;
        logic       inv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    seven_seg_decoder_if ssd ();

    seven_seg_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (ssd)
    );

    always #5 clk = ~clk;

    // Reference: list which segments a glyph lights, then convert to active-low.
    function automatic logic [6:0] ref_glyph(input int unsigned v);
        string      lit;
        logic [6:0] s;
        case (v)
            0: lit = "abcdef";
            1: lit = "bc";
            2: lit = "abdeg";
            3: lit = "abcdg";
            4: lit = "bcfg";
            5: lit = "acdfg";
            6: lit = "acdefg";
            7: lit = "abc";
            8: lit = "abcdefg";
            9: lit = "abcdfg";
`ifdef SEVEN_SEG_HEX_EN
            10: lit = "abcefg";
            11: lit = "cdefg";
            12: lit = "adef";
            13: lit = "bcdeg";
            14: lit = "adefg";
            15: lit = "aefg";
`endif
            default: lit = "";
        endcase
        s = 7'h7F;
        for (int i = 0; i < lit.len(); i++) s[lit[i] - 8'h61] = 1'b0;
        return s;
    endfunction

    function automatic exp_t model(input logic r, input logic [3:0] b,
                                   input logic bl, input logic lt);
        exp_t e;
        if (r) begin
            e.seg = 7'h7F;
            e.inv = 1'b0;
        end else begin
            e.inv = (b > 9);
            if (lt)      e.seg = 7'h00;
            else if (bl) e.seg = 7'h7F;
            else         e.seg = ref_glyph(int'(b));
        end
        return e;
    endfunction

    // Called right after a rising edge; glitches bcd mid-cycle before settling.
    task automatic apply(input logic r, input logic [3:0] b,
                         input logic bl, input logic lt);
        #1;
        ssd.bcd = 4'($urandom_range(0, 15));
        #2;
        rst           = r;
        ssd.bcd       = b;
        ssd.blank     = bl;
        ssd.lamp_test = lt;
        @(posedge clk);
        sb.push_back(model(r, b, bl, lt));
    endtask

    // Monitor: compares on the falling edge, away from the sampling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (ssd.segments !== e.seg || ssd.invalid !== e.inv) begin
                    failures++;
                    $display("FAIL decode t=%0t: segments=%h invalid=%b, required segments=%h invalid=%b",
                             $time, ssd.segments, ssd.invalid, e.seg, e.inv);
                end
            end
        end
    end

    initial begin
        ssd.bcd       = 4'd8;
        ssd.blank     = 1'b0;
        ssd.lamp_test = 1'b0;
        @(posedge clk);
        // Reset held with bcd=8, then release
        apply(1, 8, 0, 0);
        apply(1, 8, 0, 0);
        apply(0, 8, 0, 0);
        // Sweep 0..9 then the invalid range
        for (int unsigned d = 0; d < 16; d++) apply(0, 4'(d), 0, 0);
        // Blank then release
        apply(0, 3, 1, 0);
        apply(0, 3, 0, 0);
        // Lamp test over blank, then unwind
        apply(0, 1, 1, 1);
        apply(0, 1, 1, 0);
        apply(0, 1, 0, 0);
        // Lamp test / blank on invalid codes keep invalid=1
        apply(0, 12, 0, 1);
        apply(0, 14, 1, 0);
        // Mid-run reset during a sweep
        apply(0, 5, 0, 0);
        apply(1, 6, 0, 0);
        apply(0, 6, 0, 0);
        apply(0, 7, 0, 0);
        // Random phase
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 19) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0));
        end
        // Drain: monitor must consume every pushed expectation within a bound
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d, required pending=0", sb.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: simulation exceeded time budget, required completion");
            $fatal(1, "timeout");
        end
    end

endmodule
